// File: rtl/udp_header_builder.sv
// Egress UDP framer: prepends a 42-byte Ethernet II + IPv4 + UDP header to a
// 256-bit payload stream, realigning the payload by 10 bytes through a carry.
module udp_header_builder #(
  parameter logic [7:0]  TTL       = 8'd64,
  parameter logic [15:0] ETHERTYPE = 16'h0800
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [255:0] in_data,
  input  logic [31:0]  in_keep,
  input  logic         in_valid,
  input  logic         in_last,
  output logic         in_ready,
  input  logic [47:0]  dst_mac,
  input  logic [47:0]  src_mac,
  input  logic [31:0]  src_ip,
  input  logic [31:0]  dst_ip,
  input  logic [15:0]  src_port,
  input  logic [15:0]  dst_port,
  input  logic [15:0]  payload_len,
  output logic [255:0] out_data,
  output logic [31:0]  out_keep,
  output logic         out_valid,
  output logic         out_last,
  input  logic         out_ready,
  output logic         len_error
);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_MERGE, S_STREAM, S_FLUSH} state_t;

  state_t        r_state;
  logic [47:0]   r_dst_mac;
  logic [47:0]   r_src_mac;
  logic [31:0]   r_src_ip;
  logic [31:0]   r_dst_ip;
  logic [15:0]   r_src_port;
  logic [15:0]   r_dst_port;
  logic [15:0]   r_plen;
  logic [15:0]   r_csum;
  logic [15:0]   r_ip_id;
  logic [79:0]   r_carry;
  logic [15:0]   r_cnt;
  logic [5:0]    r_flush_n;
  logic          r_len_error;

  logic [5:0]    w_n;
  logic [5:0]    w_last_n;
  logic [15:0]   w_cnt_next;
  logic [15:0]   w_ip_total;
  logic [15:0]   w_udp_len;
  logic          w_payload_state;
  logic          w_fire_in;

  function automatic logic [31:0] keep_top(input logic [5:0] k);
    return ~(32'hFFFF_FFFF >> k);
  endfunction

  // End-around-carry sum of the IPv4 header words, checksum word taken as zero.
  function automatic logic [15:0] ip_csum(input logic [15:0] tot, input logic [15:0] id,
                                          input logic [31:0] sip, input logic [31:0] dip);
    logic [19:0] s;
    s = {4'd0, 16'h4500} + {4'd0, tot} + {4'd0, id} + {4'd0, 16'h4000} +
        {4'd0, TTL, 8'h11} + {4'd0, sip[31:16]} + {4'd0, sip[15:0]} +
        {4'd0, dip[31:16]} + {4'd0, dip[15:0]};
    s = {4'd0, s[15:0]} + {16'd0, s[19:16]};
    s = {4'd0, s[15:0]} + {16'd0, s[19:16]};
    return ~s[15:0];
  endfunction

  always_comb begin
    w_n = '0;
    for (int i = 0; i < 32; i++) w_n = w_n + {5'd0, in_keep[i]};
  end

  assign w_last_n        = 6'd10 + w_n;
  assign w_cnt_next      = r_cnt + {10'd0, w_n};
  assign w_ip_total      = r_plen + 16'd28;
  assign w_udp_len       = r_plen + 16'd8;
  assign w_payload_state = (r_state == S_MERGE) || (r_state == S_STREAM);
  assign w_fire_in       = w_payload_state && in_valid && out_ready;
  assign len_error       = r_len_error;

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    out_keep  = '0;
    out_last  = 1'b0;
    case (r_state)
      S_HDR: begin
        out_valid = 1'b1;
        out_keep  = '1;
        out_data  = {r_dst_mac, r_src_mac, ETHERTYPE, 8'h45, 8'h00, w_ip_total, r_ip_id,
                     16'h4000, TTL, 8'h11, r_csum, r_src_ip, r_dst_ip[31:16]};
      end
      S_MERGE, S_STREAM: begin
        in_ready  = out_ready;
        out_valid = in_valid;
        if (r_state == S_MERGE)
          out_data = {r_dst_ip[15:0], r_src_port, r_dst_port, w_udp_len, 16'h0000, in_data[255:80]};
        else
          out_data = {r_carry, in_data[255:80]};
        if (in_last && (w_n <= 6'd22)) begin
          out_last = 1'b1;
          out_keep = keep_top(w_last_n);
        end else begin
          out_keep = '1;
        end
      end
      S_FLUSH: begin
        out_valid = 1'b1;
        out_last  = 1'b1;
        out_data  = {r_carry, 176'd0};
        out_keep  = keep_top(r_flush_n);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_dst_mac   <= '0;
      r_src_mac   <= '0;
      r_src_ip    <= '0;
      r_dst_ip    <= '0;
      r_src_port  <= '0;
      r_dst_port  <= '0;
      r_plen      <= '0;
      r_csum      <= '0;
      r_ip_id     <= '0;
      r_carry     <= '0;
      r_cnt       <= '0;
      r_flush_n   <= '0;
      r_len_error <= 1'b0;
    end else begin
      r_len_error <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_dst_mac  <= dst_mac;
            r_src_mac  <= src_mac;
            r_src_ip   <= src_ip;
            r_dst_ip   <= dst_ip;
            r_src_port <= src_port;
            r_dst_port <= dst_port;
            r_plen     <= payload_len;
            r_csum     <= ip_csum(payload_len + 16'd28, r_ip_id, src_ip, dst_ip);
            r_cnt      <= '0;
            r_state    <= S_HDR;
          end
        end
        S_HDR: begin
          if (out_ready) r_state <= S_MERGE;
        end
        S_MERGE, S_STREAM: begin
          if (w_fire_in) begin
            r_carry <= in_data[79:0];
            r_cnt   <= w_cnt_next;
            if (!in_last) begin
              r_state <= S_STREAM;
            end else if (w_n <= 6'd22) begin
              r_ip_id     <= r_ip_id + 16'd1;
              r_len_error <= (w_cnt_next != r_plen);
              r_state     <= S_IDLE;
            end else begin
              r_flush_n <= w_n - 6'd22;
              r_state   <= S_FLUSH;
            end
          end
        end
        S_FLUSH: begin
          if (out_ready) begin
            r_ip_id     <= r_ip_id + 16'd1;
            r_len_error <= (r_cnt != r_plen);
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_udp_header_builder.sv
// Bench for udp_header_builder: random payloads framed by a byte-stream model
// (header bytes + payload chunked into 32-byte beats) plus literal header pins.
module tb_udp_header_builder;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] in_data;
  logic [31:0]  in_keep;
  logic         in_valid;
  logic         in_last;
  logic         in_ready;
  logic [47:0]  dst_mac, src_mac;
  logic [31:0]  src_ip, dst_ip;
  logic [15:0]  src_port, dst_port, payload_len;
  logic [255:0] out_data;
  logic [31:0]  out_keep;
  logic         out_valid, out_last, out_ready, len_error;

  always #5 clk = ~clk;

  udp_header_builder dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_keep(in_keep), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .dst_mac(dst_mac), .src_mac(src_mac), .src_ip(src_ip), .dst_ip(dst_ip),
    .src_port(src_port), .dst_port(dst_port), .payload_len(payload_len),
    .out_data(out_data), .out_keep(out_keep), .out_valid(out_valid), .out_last(out_last),
    .out_ready(out_ready), .len_error(len_error)
  );

  typedef struct {
    logic [255:0] d;
    logic [31:0]  k;
    logic         l;
  } beat_t;

  beat_t        exp_q[$];
  bit           err_q[$];
  int           checks = 0;
  int           errors = 0;
  logic [7:0]   pl[0:255];
  logic [15:0]  model_id = 16'd0;
  bit           rdy_mode = 1'b0;
  bit           gap_en = 1'b0;
  bit           mon_en = 1'b0;
  bit           pend_err = 1'b0;
  bit           was_stall = 1'b0;
  logic [255:0] prev_d;
  logic [33:0]  prev_c;
  int           pulses = 0;
  logic [255:0] cap_d[0:15];
  logic [31:0]  cap_k[0:15];
  int           cap_n = 0;
  logic [255:0] done_d[0:15];
  logic [31:0]  done_k[0:15];
  int           done_n = 0;
  beat_t        me;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference checksum: plain ones-complement sum over the ten header words.
  function automatic logic [15:0] model_csum(input logic [15:0] tot, input logic [15:0] id,
                                             input logic [31:0] sip, input logic [31:0] dip);
    int unsigned w[10];
    int unsigned sum = 0;
    w = '{32'h4500, {16'd0, tot}, {16'd0, id}, 32'h4000, 32'h4011, 32'd0,
          {16'd0, sip[31:16]}, {16'd0, sip[15:0]}, {16'd0, dip[31:16]}, {16'd0, dip[15:0]}};
    for (int i = 0; i < 10; i++) sum += w[i];
    while (sum > 32'hFFFF) sum = (sum % 65536) + (sum / 65536);
    return ~sum[15:0];
  endfunction

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rdy_mode ? ($urandom_range(0, 99) < 60) : 1'b1;
    end
  end

  always @(negedge clk) if (len_error) pulses++;

  always @(negedge clk) begin
    if (!rst && mon_en) begin
      chk("len_error", 256'(len_error), 256'(pend_err));
      pend_err = 1'b0;
      if (in_ready) chk("in_ready_follows_out_ready", 256'({out_ready, out_valid}), 256'({1'b1, in_valid}));
      if (was_stall) begin
        chk("stall_hold_data", out_data, prev_d);
        chk("stall_hold_ctl", 256'({out_keep, out_last, out_valid}), 256'(prev_c));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got data 0x%0h keep 0x%0h, expected no beat", out_data, out_keep);
        end else begin
          me = exp_q.pop_front();
          chk("out_data", out_data, me.d);
          chk("out_keep", 256'(out_keep), 256'(me.k));
          chk("out_last", 256'(out_last), 256'(me.l));
        end
        if (cap_n < 16) begin
          cap_d[cap_n] = out_data;
          cap_k[cap_n] = out_keep;
        end
        cap_n++;
        if (out_last) begin
          for (int i = 0; i < 16; i++) begin
            done_d[i] = cap_d[i];
            done_k[i] = cap_k[i];
          end
          done_n = cap_n;
          cap_n = 0;
          if (err_q.size() != 0) pend_err = err_q.pop_front();
        end
      end
      was_stall = out_valid && !out_ready;
      prev_d = out_data;
      prev_c = {out_keep, out_last, out_valid};
    end
  end

  task automatic wait_fire(output bit ok);
    int t = 0;
    bit f = 1'b0;
    do begin
      @(negedge clk);
      f = in_valid && in_ready;
      @(posedge clk);
      #1;
      t++;
    end while (!f && t < 2000);
    ok = f;
  endtask

  task automatic send_pkt(input int nb, input logic [15:0] plen, input logic [31:0] sip,
                          input logic [31:0] dip, input int abort_beats);
    logic [47:0]  dm, sm;
    logic [15:0]  sp, dp, tot, udp, cs;
    logic [335:0] hv;
    logic [7:0]   ab[0:299];
    logic [255:0] d;
    logic [31:0]  k;
    beat_t        e;
    int           tot_bytes, nbo, nbi, idx;
    bit           ok;
    for (int i = 0; i < nb; i++) pl[i] = 8'($urandom);
    dm  = {16'($urandom), 32'($urandom)};
    sm  = {16'($urandom), 32'($urandom)};
    sp  = 16'($urandom);
    dp  = 16'($urandom);
    tot = plen + 16'd28;
    udp = plen + 16'd8;
    cs  = model_csum(tot, model_id, sip, dip);
    hv  = {dm, sm, 16'h0800, 8'h45, 8'h00, tot, model_id, 16'h4000, 8'd64, 8'h11, cs,
           sip, dip, sp, dp, udp, 16'h0000};
    for (int i = 0; i < 42; i++) ab[i] = hv[335-8*i -: 8];
    for (int i = 0; i < nb; i++) ab[42+i] = pl[i];
    tot_bytes = 42 + nb;
    nbo = (tot_bytes + 31) / 32;
    for (int b = 0; b < nbo; b++) begin
      e.d = '0;
      e.k = '0;
      for (int i = 0; i < 32; i++) begin
        idx = 32*b + i;
        if (idx < tot_bytes) begin
          e.d[255-8*i -: 8] = ab[idx];
          e.k[31-i] = 1'b1;
        end
      end
      e.l = (b == nbo - 1);
      exp_q.push_back(e);
    end
    err_q.push_back(nb != int'(plen));
    model_id = model_id + 16'd1;

    dst_mac = dm; src_mac = sm; src_ip = sip; dst_ip = dip;
    src_port = sp; dst_port = dp; payload_len = plen;
    nbi = (nb == 0) ? 1 : (nb + 31) / 32;
    for (int b = 0; b < nbi; b++) begin
      if (b > 0 && gap_en && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      d = '0;
      k = '0;
      for (int i = 0; i < 32; i++) begin
        idx = 32*b + i;
        if (idx < nb) begin
          d[255-8*i -: 8] = pl[idx];
          k[31-i] = 1'b1;
        end
      end
      in_data = d;
      in_keep = k;
      in_last = (b == nbi - 1);
      in_valid = 1'b1;
      wait_fire(ok);
      if (!ok) begin
        checks++;
        errors++;
        $display("FAIL in_fire_timeout: got no input transfer in 2000 cycles, expected one");
        in_valid = 1'b0;
        in_last = 1'b0;
        return;
      end
      if (b == 0) begin
        dst_mac = {16'($urandom), 32'($urandom)};
        src_mac = {16'($urandom), 32'($urandom)};
        src_ip = $urandom; dst_ip = $urandom;
        src_port = 16'($urandom); dst_port = 16'($urandom);
        payload_len = 16'($urandom);
      end
      if (abort_beats > 0 && b + 1 == abort_beats) begin
        in_valid = 1'b0;
        in_last = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      @(posedge clk);
      t++;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("beats_outstanding", 256'(exp_q.size()), 256'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of run by 500000 ns, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [79:0] ev;
    int          p0, n;
    logic [15:0] plen;
    rst = 1'b1;
    in_data = '0; in_keep = '0; in_valid = 1'b0; in_last = 1'b0;
    dst_mac = '0; src_mac = '0; src_ip = '0; dst_ip = '0;
    src_port = '0; dst_port = '0; payload_len = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", 256'(out_valid), 256'(0));
    chk("reset_out_last", 256'(out_last), 256'(0));
    chk("reset_out_keep", 256'(out_keep), 256'(0));
    chk("reset_out_data", out_data, 256'(0));
    chk("reset_in_ready", 256'(in_ready), 256'(0));
    chk("reset_len_error", 256'(len_error), 256'(0));
    rst = 1'b0;
    mon_en = 1'b1;
    chk("model_csum_pin", 256'(model_csum(16'h0032, 16'h0000, 32'h0A000001, 32'h0A000002)), 256'(16'h26B9));

    send_pkt(22, 16'd22, 32'h0A000001, 32'h0A000002, 0);
    drain();
    chk("p22_beats", 256'(done_n), 256'(2));
    chk("p22_keep1", 256'(done_k[1]), 256'(32'hFFFFFFFF));
    chk("p22_ip_total_len", 256'(done_d[0][127:112]), 256'(16'h0032));
    chk("p22_ip_id", 256'(done_d[0][111:96]), 256'(16'h0000));
    chk("p22_ip_checksum", 256'(done_d[0][63:48]), 256'(16'h26B9));
    chk("p22_udp_len", 256'(done_d[1][207:192]), 256'(16'h001E));

    send_pkt(64, 16'd64, $urandom, $urandom, 0);
    drain();
    chk("p64_beats", 256'(done_n), 256'(4));
    chk("p64_last_keep", 256'(done_k[3]), 256'(32'hFFC00000));
    for (int i = 0; i < 10; i++) ev[79-8*i -: 8] = pl[54+i];
    chk("p64_last_bytes", 256'(done_d[3][255:176]), 256'(ev));
    chk("p64_ip_id", 256'(done_d[0][111:96]), 256'(16'h0001));

    send_pkt(23, 16'd23, $urandom, $urandom, 0);
    drain();
    chk("p23_beats", 256'(done_n), 256'(3));
    chk("p23_keep1", 256'(done_k[1]), 256'(32'hFFFFFFFF));
    chk("p23_keep2", 256'(done_k[2]), 256'(32'h80000000));
    chk("p23_byte22", 256'(done_d[2][255:248]), 256'(pl[22]));
    chk("p23_ip_id", 256'(done_d[0][111:96]), 256'(16'h0002));

    send_pkt(0, 16'd0, $urandom, $urandom, 0);
    drain();
    chk("p0_beats", 256'(done_n), 256'(2));
    chk("p0_keep1", 256'(done_k[1]), 256'(32'hFFC00000));
    chk("p0_udp_len", 256'(done_d[1][207:192]), 256'(16'h0008));
    chk("p0_ip_total_len", 256'(done_d[0][127:112]), 256'(16'h001C));

    rdy_mode = 1'b1;
    gap_en = 1'b1;
    send_pkt(100, 16'd100, $urandom, $urandom, 0);
    drain();
    chk("p100_beats", 256'(done_n), 256'(5));
    rdy_mode = 1'b0;
    gap_en = 1'b0;

    p0 = pulses;
    send_pkt(30, 16'd40, $urandom, $urandom, 0);
    drain();
    chk("len_error_pulses", 256'(pulses - p0), 256'(1));
    chk("len30_ip_total_len", 256'(done_d[0][127:112]), 256'(16'd68));

    send_pkt(200, 16'd200, $urandom, $urandom, 3);
    in_data = {8{$urandom}};
    in_keep = '1;
    in_last = 1'b0;
    in_valid = 1'b1;
    #1;
    chk("pre_reset_stream_valid", 256'(out_valid), 256'(1));
    #1;
    rst = 1'b1;
    #1;
    chk("midpkt_reset_out_valid", 256'(out_valid), 256'(0));
    chk("midpkt_reset_out_data", out_data, 256'(0));
    chk("midpkt_reset_out_keep", 256'({out_keep, out_last}), 256'(0));
    chk("midpkt_reset_in_ready", 256'({in_ready, len_error}), 256'(0));
    in_valid = 1'b0;
    exp_q.delete();
    err_q.delete();
    pend_err = 1'b0;
    was_stall = 1'b0;
    cap_n = 0;
    model_id = 16'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    send_pkt(40, 16'd40, $urandom, $urandom, 0);
    drain();
    chk("post_reset_beats", 256'(done_n), 256'(3));
    chk("post_reset_ip_id", 256'(done_d[0][111:96]), 256'(16'h0000));

    for (int p = 0; p < 40; p++) begin
      rdy_mode = 1'($urandom_range(0, 1));
      gap_en = 1'($urandom_range(0, 1));
      n = $urandom_range(0, 160);
      plen = ($urandom_range(0, 5) == 0) ? 16'($urandom_range(0, 200)) : 16'(n);
      send_pkt(n, plen, $urandom, $urandom, 0);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
